// File: rtl/dvfs_level_energy_engine_if.sv
// Task request / result channel bundle for the DVFS level and energy engine.
// master = task producer and result consumer; slave = the engine.
interface dvfs_level_energy_engine_if #(
  parameter int TAG_WIDTH     = 4,
  parameter int PROC_ID_WIDTH = 3,
  parameter int DATA_WIDTH    = 64,
  parameter int LEVEL_WIDTH   = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [TAG_WIDTH-1:0]     in_task_id;
  logic [PROC_ID_WIDTH-1:0] in_proc;
  logic [DATA_WIDTH-1:0]    in_wcet;
  logic [DATA_WIDTH-1:0]    in_budget;

  logic                     out_valid;
  logic                     out_ready;
  logic [TAG_WIDTH-1:0]     out_task_id;
  logic [PROC_ID_WIDTH-1:0] out_proc;
  logic [LEVEL_WIDTH-1:0]   out_level;
  logic [DATA_WIDTH-1:0]    out_freq;
  logic [DATA_WIDTH-1:0]    out_energy;
  logic                     out_miss;
  logic                     out_proc_err;

  modport master (
    output in_valid, in_task_id, in_proc, in_wcet, in_budget, out_ready,
    input  in_ready, out_valid, out_task_id, out_proc, out_level, out_freq,
           out_energy, out_miss, out_proc_err
  );

  modport slave (
    input  in_valid, in_task_id, in_proc, in_wcet, in_budget, out_ready,
    output in_ready, out_valid, out_task_id, out_proc, out_level, out_freq,
           out_energy, out_miss, out_proc_err
  );
endinterface

// File: rtl/dvfs_level_energy_engine.sv
// Per-task DVFS level selector and saturating energy accountant.
// Scans the f/v table from the slowest level upward, picks the lowest
// frequency that still meets the task budget, then computes v^2 * wcet * C_EFF.
//
// state | meaning
// IDLE  | waiting for a task; in_ready high
// SCAN  | testing one table level per cycle, starting at L-1
// CALC  | computing energy for the chosen level
// HOLD  | result presented until out_ready
module dvfs_level_energy_engine #(
  parameter int NUM_PROCESSORS = 3,
  parameter int L              = 8,
  parameter int DATA_WIDTH     = 64,
  parameter int FRAC_BITS      = 32,
  parameter int C_EFF          = 1,
  parameter int PROC_ID_WIDTH  = 3,
  parameter int TAG_WIDTH      = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [L*DATA_WIDTH-1:0]            f,
  input  logic [L*DATA_WIDTH-1:0]            v,
  dvfs_level_energy_engine_if.slave          bus,
  input  logic                               clear_acc,
  output logic [NUM_PROCESSORS*DATA_WIDTH-1:0] proc_energy,
  output logic [DATA_WIDTH-1:0]              E_total,
  output logic                               acc_sat,
  output logic                               busy
);
  localparam int LW = $clog2(L);
  localparam int EW = 3*DATA_WIDTH + 32;
  localparam logic [31:0] C_EFF_U = 32'(C_EFF);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_CALC, S_HOLD} state_t;

  state_t                   state_q, state_d;
  logic [LW-1:0]            idx_q, idx_d;
  logic [TAG_WIDTH-1:0]     tag_q, tag_d;
  logic [PROC_ID_WIDTH-1:0] proc_q, proc_d;
  logic [DATA_WIDTH-1:0]    wcet_q, wcet_d, budget_q, budget_d;
  logic                     miss_q, miss_d;
  logic                     in_ready_q, in_ready_d, busy_q, busy_d;
  logic                     out_valid_q, out_valid_d, out_miss_q, out_miss_d;
  logic                     out_perr_q, out_perr_d;
  logic [TAG_WIDTH-1:0]     out_tag_q, out_tag_d;
  logic [PROC_ID_WIDTH-1:0] out_proc_q, out_proc_d;
  logic [LW-1:0]            out_level_q, out_level_d;
  logic [DATA_WIDTH-1:0]    out_freq_q, out_freq_d, out_energy_q, out_energy_d;
  logic [DATA_WIDTH-1:0]    etot_q, etot_d;
  logic [DATA_WIDTH-1:0]    proc_acc_q [NUM_PROCESSORS];
  logic [DATA_WIDTH-1:0]    proc_acc_d [NUM_PROCESSORS];
  logic                     acc_sat_q, acc_sat_d;

  logic [DATA_WIDTH-1:0]    f_arr [L];
  logic [DATA_WIDTH-1:0]    v_arr [L];
  logic [2*DATA_WIDTH-1:0]  need, have, v_ext, vsq;
  logic [EW-1:0]            e_full;
  logic [DATA_WIDTH-1:0]    energy;
  logic                     fit, proc_ok, accept, res_edge;
  logic [DATA_WIDTH:0]      sum;

  for (genvar k = 0; k < L; k++) begin : g_tab
    assign f_arr[k] = f[k*DATA_WIDTH +: DATA_WIDTH];
    assign v_arr[k] = v[k*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar p = 0; p < NUM_PROCESSORS; p++) begin : g_pe
    assign proc_energy[p*DATA_WIDTH +: DATA_WIDTH] = proc_acc_q[p];
  end

  // Saturating add; the extra top bit flags that saturation happened.
  function automatic logic [DATA_WIDTH:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[DATA_WIDTH]) s = {1'b1, {DATA_WIDTH{1'b1}}};
    return s;
  endfunction

  // Level test, energy arithmetic and all next-state/next-output values.
  always_comb begin
    need     = {{DATA_WIDTH{1'b0}}, wcet_q} * {{DATA_WIDTH{1'b0}}, f_arr[0]};
    have     = {{DATA_WIDTH{1'b0}}, budget_q} * {{DATA_WIDTH{1'b0}}, f_arr[idx_q]};
    fit      = (f_arr[idx_q] != '0) && (need <= have);
    v_ext    = {{DATA_WIDTH{1'b0}}, v_arr[idx_q]};
    vsq      = (v_ext * v_ext) >> FRAC_BITS;
    e_full   = EW'(vsq) * EW'(wcet_q) * EW'(C_EFF_U);
    energy   = (|e_full[EW-1:DATA_WIDTH]) ? '1 : e_full[DATA_WIDTH-1:0];
    proc_ok  = int'(proc_q) < NUM_PROCESSORS;
    accept   = in_ready_q & bus.in_valid;
    res_edge = (state_q == S_CALC);
    sum      = '0;

    state_d      = state_q;
    idx_d        = idx_q;
    tag_d        = tag_q;
    proc_d       = proc_q;
    wcet_d       = wcet_q;
    budget_d     = budget_q;
    miss_d       = miss_q;
    out_valid_d  = out_valid_q;
    out_tag_d    = out_tag_q;
    out_proc_d   = out_proc_q;
    out_level_d  = out_level_q;
    out_freq_d   = out_freq_q;
    out_energy_d = out_energy_q;
    out_miss_d   = out_miss_q;
    out_perr_d   = out_perr_q;
    etot_d       = etot_q;
    proc_acc_d   = proc_acc_q;
    acc_sat_d    = acc_sat_q;

    case (state_q)
      S_IDLE: if (accept) begin
        state_d  = S_SCAN;
        idx_d    = LW'(L-1);
        tag_d    = bus.in_task_id;
        proc_d   = bus.in_proc;
        wcet_d   = bus.in_wcet;
        budget_d = bus.in_budget;
      end
      S_SCAN: begin
        if (fit) begin
          state_d = S_CALC;
          miss_d  = 1'b0;
        end else if (idx_q == '0) begin
          state_d = S_CALC;
          miss_d  = 1'b1;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_CALC: begin
        state_d      = S_HOLD;
        out_valid_d  = 1'b1;
        out_tag_d    = tag_q;
        out_proc_d   = proc_q;
        out_level_d  = idx_q;
        out_freq_d   = f_arr[idx_q];
        out_energy_d = energy;
        out_miss_d   = miss_q;
        out_perr_d   = !proc_ok;
      end
      S_HOLD: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);

    // A clear wins, but a result landing on the same edge is still counted.
    if (clear_acc) begin
      etot_d    = '0;
      acc_sat_d = 1'b0;
      for (int p = 0; p < NUM_PROCESSORS; p++) proc_acc_d[p] = '0;
      if (res_edge) begin
        etot_d = energy;
        for (int p = 0; p < NUM_PROCESSORS; p++)
          if (proc_ok && proc_q == PROC_ID_WIDTH'(p)) proc_acc_d[p] = energy;
      end
    end else if (res_edge) begin
      sum    = sat_add(etot_q, energy);
      etot_d = sum[DATA_WIDTH-1:0];
      if (sum[DATA_WIDTH]) acc_sat_d = 1'b1;
      for (int p = 0; p < NUM_PROCESSORS; p++) begin
        if (proc_ok && proc_q == PROC_ID_WIDTH'(p)) begin
          sum           = sat_add(proc_acc_q[p], energy);
          proc_acc_d[p] = sum[DATA_WIDTH-1:0];
          if (sum[DATA_WIDTH]) acc_sat_d = 1'b1;
        end
      end
    end
  end

  // FSM state, task registers, result registers and accumulators.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      tag_q        <= '0;
      proc_q       <= '0;
      wcet_q       <= '0;
      budget_q     <= '0;
      miss_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_tag_q    <= '0;
      out_proc_q   <= '0;
      out_level_q  <= '0;
      out_freq_q   <= '0;
      out_energy_q <= '0;
      out_miss_q   <= 1'b0;
      out_perr_q   <= 1'b0;
      etot_q       <= '0;
      acc_sat_q    <= 1'b0;
      for (int p = 0; p < NUM_PROCESSORS; p++) proc_acc_q[p] <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tag_q        <= tag_d;
      proc_q       <= proc_d;
      wcet_q       <= wcet_d;
      budget_q     <= budget_d;
      miss_q       <= miss_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_tag_q    <= out_tag_d;
      out_proc_q   <= out_proc_d;
      out_level_q  <= out_level_d;
      out_freq_q   <= out_freq_d;
      out_energy_q <= out_energy_d;
      out_miss_q   <= out_miss_d;
      out_perr_q   <= out_perr_d;
      etot_q       <= etot_d;
      acc_sat_q    <= acc_sat_d;
      for (int p = 0; p < NUM_PROCESSORS; p++) proc_acc_q[p] <= proc_acc_d[p];
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_task_id  = out_tag_q;
  assign bus.out_proc     = out_proc_q;
  assign bus.out_level    = out_level_q;
  assign bus.out_freq     = out_freq_q;
  assign bus.out_energy   = out_energy_q;
  assign bus.out_miss     = out_miss_q;
  assign bus.out_proc_err = out_perr_q;
  assign E_total          = etot_q;
  assign acc_sat          = acc_sat_q;
  assign busy             = busy_q;
endmodule

// File: tb/tb_dvfs_level_energy_engine.sv
// Bench for dvfs_level_energy_engine: transaction-level reference model,
// per-cycle comparison, directed cases with literal expectations, random traffic.
module tb_dvfs_level_energy_engine;
  localparam int NP = 3, L = 8, DW = 64, FB = 32, CE = 1, PW = 3, TW = 4, LW = 3;

  logic clk = 1'b0;
  logic reset, clear_acc;
  logic [L*DW-1:0]  f_bus, v_bus;
  logic [DW-1:0]    f_tab [L];
  logic [DW-1:0]    v_tab [L];
  logic [NP*DW-1:0] proc_energy;
  logic [DW-1:0]    E_total;
  logic             acc_sat, busy;

  always #5 clk = ~clk;

  dvfs_level_energy_engine_if #(.TAG_WIDTH(TW), .PROC_ID_WIDTH(PW), .DATA_WIDTH(DW),
                                .LEVEL_WIDTH(LW)) bus();

  dvfs_level_energy_engine #(.NUM_PROCESSORS(NP), .L(L), .DATA_WIDTH(DW), .FRAC_BITS(FB),
                             .C_EFF(CE), .PROC_ID_WIDTH(PW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .f(f_bus), .v(v_bus), .bus(bus), .clear_acc(clear_acc),
    .proc_energy(proc_energy), .E_total(E_total), .acc_sat(acc_sat), .busy(busy));

  always_comb begin
    f_bus = '0;
    v_bus = '0;
    for (int k = 0; k < L; k++) begin
      f_bus[k*DW +: DW] = f_tab[k];
      v_bus[k*DW +: DW] = v_tab[k];
    end
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [TW-1:0] tag;
    logic [PW-1:0] proc;
    logic [63:0]   level;
    logic [63:0]   freq;
    logic [63:0]   energy;
    logic          miss;
    logic          perr;
  } res_t;

  // Slowest table entry whose run time wcet*f0/f[k] fits the budget.
  function automatic void model_pick(input logic [63:0] wcet, input logic [63:0] budget,
                                     output int lvl, output bit miss);
    logic [127:0] need, have;
    lvl  = -1;
    need = 128'(wcet) * 128'(f_tab[0]);
    for (int k = 0; k < L; k++) begin
      have = 128'(budget) * 128'(f_tab[k]);
      if (f_tab[k] != 0 && need <= have) lvl = k;
    end
    miss = (lvl < 0);
    if (miss) lvl = 0;
  endfunction

  function automatic logic [63:0] model_energy(input logic [63:0] wcet, input logic [63:0] vv);
    logic [127:0] vsq;
    logic [255:0] e;
    vsq = (128'(vv) * 128'(vv)) >> FB;
    e   = 256'(vsq) * 256'(wcet) * 256'(CE);
    return (e[255:64] != 0) ? '1 : e[63:0];
  endfunction

  bit          m_ready, m_pending, m_hold, m_sat, res_edge, m_miss;
  int          m_cnt, m_lvl;
  res_t        m_out, m_next;
  logic [63:0] m_etot;
  logic [63:0] m_acc [NP];

  function automatic logic [63:0] madd(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = 65'(a) + 65'(b);
    if (s[64]) begin
      m_sat = 1;
      return '1;
    end
    return s[63:0];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ready = 0; m_pending = 0; m_hold = 0; m_cnt = 0; m_sat = 0; m_etot = 0;
      m_out = '{tag: 0, proc: 0, level: 0, freq: 0, energy: 0, miss: 0, perr: 0};
      for (int p = 0; p < NP; p++) m_acc[p] = 0;
    end else begin
      res_edge = 0;
      if (!m_pending && !m_hold) begin
        if (m_ready && bus.in_valid) begin
          model_pick(bus.in_wcet, bus.in_budget, m_lvl, m_miss);
          m_next.tag    = bus.in_task_id;
          m_next.proc   = bus.in_proc;
          m_next.level  = 64'(m_lvl);
          m_next.freq   = f_tab[m_lvl];
          m_next.energy = model_energy(bus.in_wcet, v_tab[m_lvl]);
          m_next.miss   = m_miss;
          m_next.perr   = int'(bus.in_proc) >= NP;
          m_cnt     = L - m_lvl + 1;
          m_pending = 1;
          m_ready   = 0;
        end else begin
          m_ready = 1;
        end
      end else if (m_pending) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_pending = 0; m_hold = 1; m_out = m_next; res_edge = 1;
        end
      end else if (bus.out_ready) begin
        m_hold = 0; m_ready = 1;
      end
      if (clear_acc) begin
        m_etot = 0; m_sat = 0;
        for (int p = 0; p < NP; p++) m_acc[p] = 0;
        if (res_edge) begin
          m_etot = m_out.energy;
          if (!m_out.perr) m_acc[m_out.proc] = m_out.energy;
        end
      end else if (res_edge) begin
        m_etot = madd(m_etot, m_out.energy);
        if (!m_out.perr) m_acc[m_out.proc] = madd(m_acc[m_out.proc], m_out.energy);
      end
    end
  end

  // Every cycle: compare all DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 64'(bus.in_ready), 64'(m_ready));
      chk("busy", 64'(busy), 64'(m_pending || m_hold));
      chk("out_valid", 64'(bus.out_valid), 64'(m_hold));
      chk("out_task_id", 64'(bus.out_task_id), 64'(m_out.tag));
      chk("out_proc", 64'(bus.out_proc), 64'(m_out.proc));
      chk("out_level", 64'(bus.out_level), m_out.level);
      chk("out_freq", bus.out_freq, m_out.freq);
      chk("out_energy", bus.out_energy, m_out.energy);
      chk("out_miss", 64'(bus.out_miss), 64'(m_out.miss));
      chk("out_proc_err", 64'(bus.out_proc_err), 64'(m_out.perr));
      chk("E_total", E_total, m_etot);
      chk("acc_sat", 64'(acc_sat), 64'(m_sat));
      for (int p = 0; p < NP; p++)
        chk($sformatf("proc_energy[%0d]", p), proc_energy[p*DW +: DW], m_acc[p]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_task(input logic [TW-1:0] tag, input logic [PW-1:0] proc,
                           input logic [63:0] wcet, input logic [63:0] budget);
    bit ok = 0;
    bus.in_task_id = tag; bus.in_proc = proc; bus.in_wcet = wcet; bus.in_budget = budget;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bus.in_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.in_wcet    = {$urandom, $urandom};
    bus.in_budget  = {$urandom, $urandom};
    bus.in_proc    = PW'($urandom);
    bus.in_task_id = TW'($urandom);
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout at %0t: actual=no accept required=accept", $time);
    end
  endtask

  task automatic run_task(input logic [TW-1:0] tag, input logic [PW-1:0] proc,
                          input logic [63:0] wcet, input logic [63:0] budget,
                          input int hold, input int exp_lat, input bit clr);
    int lat = 0;
    send_task(tag, proc, wcet, budget);
    while (!bus.out_valid && lat < 40) begin
      if (clr && lat == exp_lat - 1) clear_acc = 1'b1;
      @(negedge clk);
      clear_acc = 1'b0;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    repeat (hold) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog at %0t: actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lvl;
    bit miss;
    logic [63:0] w, b;
    f_tab = '{64'd1500, 64'd1300, 64'd1100, 64'd900, 64'd667, 64'd600, 64'd500, 64'd400};
    v_tab = '{64'd5798205850, 64'd5583457485, 64'd5368709120, 64'd4939212390,
              64'd4509715661, 64'd4294967296, 64'd4080218931, 64'd3865470566};
    reset = 1'b1; clear_acc = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_task_id = '0; bus.in_proc = '0;
    bus.in_wcet = '0; bus.in_budget = '0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    reset = 1'b0;
    @(negedge clk);

    // Hand-computed pins on the model itself.
    model_pick(10, 100, lvl, miss); chk("pin lvl b100", 64'(lvl), 7);
    model_pick(10, 30, lvl, miss);  chk("pin lvl b30", 64'(lvl), 6);
    model_pick(10, 14, lvl, miss);  chk("pin lvl b14", 64'(lvl), 2);
    model_pick(10, 10, lvl, miss);  chk("pin lvl b10", 64'(lvl), 0); chk("pin miss b10", 64'(miss), 0);
    model_pick(10, 5, lvl, miss);   chk("pin miss b5", 64'(miss), 1);
    chk("pin energy v1.25", model_energy(10, v_tab[2]), 64'd67108864000);
    chk("pin energy v1.00", model_energy(10, v_tab[5]), 64'd42949672960);

    run_task(4'd1, 3'd0, 10, 100, 0, 2, 0);
    chk("t1 E_total", E_total, 64'd34789235090);
    chk("t1 proc0", proc_energy[63:0], 64'd34789235090);
    run_task(4'd2, 3'd1, 10, 30, 0, 3, 0);
    chk("t2 freq", bus.out_freq, 64'd500);
    run_task(4'd3, 3'd2, 10, 10, 0, 9, 0);
    chk("t2b miss", 64'(bus.out_miss), 0);
    run_task(4'd4, 3'd0, 10, 5, 0, 9, 0);
    chk("t3 miss", 64'(bus.out_miss), 1);
    run_task(4'd5, 3'd1, 10, 14, 5, 7, 0);
    chk("t4 energy", bus.out_energy, 64'd67108864000);
    chk("t4 level", 64'(bus.out_level), 2);

    clear_acc = 1'b1; @(negedge clk); clear_acc = 1'b0;
    run_task(4'd6, 3'd5, 10, 25, 0, 4, 1);
    chk("t5 E_total", E_total, 64'd42949672960);
    chk("t5 proc_energy", proc_energy[63:0] | proc_energy[127:64] | proc_energy[191:128], 0);
    chk("t5 proc_err", 64'(bus.out_proc_err), 1);

    run_task(4'd7, 3'd2, 0, 3, 0, 2, 0);
    chk("wcet0 energy", bus.out_energy, 0);
    f_tab[7] = 0;
    run_task(4'd8, 3'd0, 0, 0, 0, 3, 0);
    chk("f0 skip level", 64'(bus.out_level), 6);
    f_tab[7] = 400;

    clear_acc = 1'b1; @(negedge clk); clear_acc = 1'b0;
    run_task(4'd9, 3'd1, 64'h4000_0000_0000_0000, '1, 0, 2, 0);
    chk("sat energy", bus.out_energy, '1);
    chk("sat first", 64'(acc_sat), 0);
    run_task(4'd10, 3'd1, 64'h4000_0000_0000_0000, '1, 0, 2, 0);
    chk("sat second", 64'(acc_sat), 1);
    run_task(4'd11, 3'd2, 10, 100, 0, 2, 0);
    chk("sat sticky", 64'(acc_sat), 1);

    send_task(4'd12, 3'd1, 10, 5);
    repeat (3) @(negedge clk);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk("rst E_total", E_total, 0);
    chk("rst acc_sat", 64'(acc_sat), 0);
    chk("rst in_ready", 64'(bus.in_ready), 0);
    @(negedge clk);
    chk("rst ready after", 64'(bus.in_ready), 1);
    run_task(4'd13, 3'd2, 10, 30, 2, 3, 0);

    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 399) == 0);
      clear_acc     = ($urandom_range(0, 49) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.in_valid  = $urandom_range(0, 1);
      bus.in_task_id = TW'($urandom);
      bus.in_proc    = ($urandom_range(0, 3) == 0) ? PW'($urandom) : PW'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0: begin w = 0; b = 64'($urandom_range(0, 10)); end
        1, 2: begin w = {$urandom, $urandom}; b = {$urandom, $urandom}; end
        3: begin w = 64'($urandom) << 30; b = '1; end
        default: begin
          w = 64'($urandom_range(1, 1000));
          b = (w * 64'($urandom_range(50, 400))) / 100;
        end
      endcase
      bus.in_wcet = w; bus.in_budget = b;
      @(negedge clk);
    end
    reset = 1'b0; clear_acc = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
